// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - request/response bundle for the iterative divider
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       func;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, func, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, func, dividend, divisor, flush,
        output busy, done, result
    );
endinterface

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU
// One quotient bit per cycle; divide-by-zero and signed overflow finish immediately.
module iter_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    iter_divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nxt;
    logic [1:0]       func_q;
    logic             quot_neg, rem_neg;
    logic [WIDTH-1:0] quot, rem, dvs_mag, result_q;
    logic [CNT_W-1:0] cnt;

    logic             accept, is_signed_in, dvd_neg_in, dvs_neg_in;
    logic             div_zero, signed_ovf, special;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] rem_step, quot_step, final_res;
    logic             last_step;

    assign accept       = (state == IDLE) && bus.start && !bus.flush;
    assign is_signed_in = !bus.func[0];
    assign dvd_neg_in   = is_signed_in && bus.dividend[WIDTH-1];
    assign dvs_neg_in   = is_signed_in && bus.divisor[WIDTH-1];
    assign div_zero     = (bus.divisor == '0);
    assign signed_ovf   = is_signed_in && (bus.dividend == MIN_NEG) && (bus.divisor == ALL_ONES);
    assign special      = div_zero || signed_ovf;
    assign special_res  = div_zero ? (bus.func[1] ? bus.dividend : ALL_ONES)
                                   : (bus.func[1] ? '0 : bus.dividend);

    // The quotient register doubles as the dividend shifter; its MSB feeds the partial remainder.
    assign rem_sh    = {rem, quot[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvs_mag};
    assign rem_step  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_step = {quot[WIDTH-2:0], ~diff[WIDTH]};
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign final_res = func_q[1] ? (rem_neg  ? -rem_step  : rem_step)
                                 : (quot_neg ? -quot_step : quot_step);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func_q   <= '0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            dvs_mag  <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (accept) begin
            func_q   <= bus.func;
            quot_neg <= dvd_neg_in ^ dvs_neg_in;
            rem_neg  <= dvd_neg_in;
            quot     <= dvd_neg_in ? -bus.dividend : bus.dividend;
            dvs_mag  <= dvs_neg_in ? -bus.divisor : bus.divisor;
            rem      <= '0;
            cnt      <= '0;
            if (special) result_q <= special_res;
        end else if (state == CALC && !bus.flush) begin
            quot <= quot_step;
            rem  <= rem_step;
            cnt  <= cnt + 1'b1;
            if (last_step) result_q <= final_res;
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - self-checking bench for iter_divider at WIDTH=32 and WIDTH=8
module tb_iter_divider;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    iter_divider_if #(.WIDTH(32)) if_a ();
    iter_divider_if #(.WIDTH(8))  if_b ();

    iter_divider #(.WIDTH(32)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    iter_divider #(.WIDTH(8))  dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        tbl[14];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (if_a.done === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL done_a_unexpected actual=1 required=0 result=%h", if_a.result);
            end else begin
                logic [63:0] e;
                e = qa.pop_front();
                if ({32'b0, if_a.result} !== e) begin
                    errors++;
                    $display("FAIL result_a actual=%h required=%h", if_a.result, e);
                end
            end
        end
        if (if_b.done === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL done_b_unexpected actual=1 required=0 result=%h", if_b.result);
            end else begin
                logic [63:0] e;
                e = qb.pop_front();
                if ({56'b0, if_b.result} !== e) begin
                    errors++;
                    $display("FAIL result_b actual=%h required=%h", if_b.result, e);
                end
            end
        end
    end

    function automatic logic get_busy(bit w);
        return w ? if_b.busy : if_a.busy;
    endfunction

    function automatic logic get_done(bit w);
        return w ? if_b.done : if_a.done;
    endfunction

    function automatic logic [63:0] get_result(bit w);
        return w ? {56'b0, if_b.result} : {32'b0, if_a.result};
    endfunction

    task automatic set_in(bit w, logic s, logic [1:0] f, logic [63:0] a, logic [63:0] b);
        if (w) begin
            if_b.start = s; if_b.func = f; if_b.dividend = a[7:0]; if_b.divisor = b[7:0];
        end else begin
            if_a.start = s; if_a.func = f; if_a.dividend = a[31:0]; if_a.divisor = b[31:0];
        end
    endtask

    function automatic logic [63:0] ref_res(int wd, logic [1:0] f, logic [63:0] a, logic [63:0] b);
        logic [63:0] mask, ua, ub, res;
        longint      sa, sb;
        mask = (64'd1 << wd) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        sa   = $signed(ua << (64 - wd)) >>> (64 - wd);
        sb   = $signed(ub << (64 - wd)) >>> (64 - wd);
        if (ub == 0)    res = f[1] ? ua : mask;
        else if (!f[0]) res = f[1] ? 64'(sa % sb) : 64'(sa / sb);
        else            res = f[1] ? ua % ub : ua / ub;
        return res & mask;
    endfunction

    task automatic op(bit w, logic [1:0] f, logic [63:0] a, logic [63:0] b,
                      logic [63:0] exp, int lat, int inj, string name);
        int cyc, bcnt, guard;
        guard = 0;
        while (get_busy(w) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (w) qb.push_back(exp); else qa.push_back(exp);
        set_in(w, 1'b1, f, a, b);
        @(posedge clk); #1;
        set_in(w, 1'b0, f, a, b);
        cyc = 1; bcnt = 0;
        forever begin
            if (get_busy(w)) bcnt++;
            if (get_done(w) || cyc >= 200) break;
            if (cyc == inj) set_in(w, 1'b1, ~f, ~a, b + 3);
            else            set_in(w, 1'b0, f, a, b);
            @(posedge clk); #1; cyc++;
        end
        set_in(w, 1'b0, f, a, b);
        check({name, "_latency"}, 64'(cyc), 64'(lat));
        check({name, "_busy_cycles"}, 64'(bcnt), 64'(lat));
        @(posedge clk); #1;
        check({name, "_done_busy_after"}, {62'b0, get_done(w), get_busy(w)}, 64'd0);
        check({name, "_hold"}, get_result(w), exp);
    endtask

    task automatic rand_op(bit w, int i);
        int          wd, sel, lat;
        logic [1:0]  f;
        logic [63:0] mask, a, b, exp;
        wd   = w ? 8 : 32;
        mask = (64'd1 << wd) - 64'd1;
        f    = 2'($urandom_range(0, 3));
        a    = {$urandom, $urandom} & mask;
        b    = {$urandom, $urandom} & mask;
        sel  = $urandom_range(0, 9);
        if (sel == 0) b = 0;
        if (sel == 1) begin a = 64'd1 << (wd - 1); b = mask; f[0] = 1'b0; end
        if (sel == 2) b = 64'($urandom_range(1, 5));
        exp = ref_res(wd, f, a, b);
        lat = (b == 0 || (!f[0] && a == (64'd1 << (wd - 1)) && b == mask)) ? 1 : wd + 1;
        op(w, f, a, b, exp, lat, 0, $sformatf("rand%0d_w%0d", i, wd));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{2'b00, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
        tbl[1]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
        tbl[2]  = '{2'b01, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 1};
        tbl[3]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 1};
        tbl[4]  = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        tbl[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        tbl[6]  = '{2'b01, 32'd1000,     32'd7,        32'h0000008E, 33};
        tbl[7]  = '{2'b11, 32'd1000,     32'd7,        32'h00000006, 33};
        tbl[8]  = '{2'b00, 32'h00000064, 32'hFFFFFFF6, 32'hFFFFFFF6, 33};
        tbl[9]  = '{2'b10, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 33};
        tbl[10] = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33};
        tbl[11] = '{2'b00, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1};
        tbl[12] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        tbl[13] = '{2'b01, 32'h00000005, 32'h00000009, 32'h00000000, 33};

        set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        set_in(1'b1, 1'b0, 2'b00, 64'd0, 64'd0);
        if_a.flush = 1'b0;
        if_b.flush = 1'b0;

        #1 rst = 1'b1;
        #1;
        check("reset_a", {if_a.busy, if_a.done, if_a.result}, 64'd0);
        check("reset_b", {if_b.busy, if_b.done, if_b.result}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 14; i++)
            op(1'b0, tbl[i].f, 64'(tbl[i].a), 64'(tbl[i].b), 64'(tbl[i].exp),
               tbl[i].lat, 0, $sformatf("vec%0d", i));

        op(1'b0, 2'b01, 64'd1000, 64'd7, 64'h8E, 33, 5, "ignored_start");

        set_in(1'b0, 1'b1, 2'b01, 64'd1000, 64'd7);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 2'b01, 64'd1000, 64'd7);
        repeat (9) begin @(posedge clk); #1; end
        if_a.flush = 1'b1;
        @(posedge clk); #1;
        if_a.flush = 1'b0;
        check("flush_busy", 64'(if_a.busy), 64'd0);
        repeat (40) begin @(posedge clk); #1; end
        check("flush_hold", 64'(if_a.result), 64'h8E);

        set_in(1'b0, 1'b1, 2'b00, 64'd50, 64'd5);
        if_a.flush = 1'b1;
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 2'b00, 64'd50, 64'd5);
        if_a.flush = 1'b0;
        check("flush_start_idle", 64'(if_a.busy), 64'd0);

        op(1'b0, 2'b01, 64'd1000, 64'd7, 64'h8E, 33, 0, "after_flush");

        set_in(1'b0, 1'b1, 2'b00, 64'h12345678, 64'd3);
        set_in(1'b1, 1'b1, 2'b00, 64'h7B, 64'd3);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
        set_in(1'b1, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (4) begin @(posedge clk); #1; end
        check("midcalc_busy", {62'b0, if_a.busy, if_b.busy}, 64'd3);
        #2 rst = 1'b1;
        #1;
        check("async_reset_a", {if_a.busy, if_a.done, if_a.result}, 64'd0);
        check("async_reset_b", {if_b.busy, if_b.done, if_b.result}, 64'd0);
        #1 rst = 1'b0;

        op(1'b0, 2'b10, 64'hFFFFFF9C, 64'd7, 64'hFFFFFFFE, 33, 0, "after_reset");

        for (int i = 0; i < 30; i++) rand_op(1'b0, i);
        for (int i = 0; i < 40; i++) rand_op(1'b1, i);

        repeat (3) @(posedge clk);
        check("queue_a_empty", 64'(qa.size()), 64'd0);
        check("queue_b_empty", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
